// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } stall_state_e;

  localparam int unsigned REG_W_DEFAULT = 5;
  localparam logic [4:0]  XZR           = 5'd31;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-info inputs and register-bank control outputs of the stall controller.
// master = pipeline side driving hazard info, slave = the controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [31:0]      stall_cycles;

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_mem_read, ex_rd, ex_branch_taken, mem_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, stall_cycles
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_mem_read, ex_rd, ex_branch_taken, mem_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, stall_cycles
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing the data-memory wait; zero flags the release cycle.
module mem_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: memory wait, branch flush, load-use stall.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned REG_W   = REG_W_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave bus
);

  // First frozen cycle happens in RUN, so the counter covers the remaining MEM_LAT-1.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

  stall_state_e state_q, state_d;

  logic cnt_load, cnt_dec, cnt_zero;
  logic mem_stall, load_use;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;

  mem_wait_counter #(
    .CNT_W(CNT_W)
  ) u_mem_wait_counter (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .value(LOAD_VAL),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  assign mem_stall = bus.mem_req && (MEM_LAT > 0);

  assign load_use = bus.ex_mem_read && (bus.ex_rd != REG_W'(XZR)) &&
                    ((bus.id_uses_rn && (bus.id_rn == bus.ex_rd)) ||
                     (bus.id_uses_rm && (bus.id_rm == bus.ex_rd)));

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (reset) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
          end else if (bus.ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        ST_WAIT: begin
          if (!cnt_zero) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            cnt_dec = 1'b1;
          end else begin
            // Branch held in EX during the freeze is flushed on the release cycle.
            state_d = ST_RUN;
            if (bus.ex_branch_taken) begin
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        any_stall;

  assign any_stall = ~&{pc_en, ifid_en, idex_en, exmem_en, memwb_en};

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (any_stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule
